// File: rtl/io_out_arbiter.sv
// rtl/io_out_arbiter.sv - round-robin, length-bounded time-share of one output register cell bank
module io_out_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int LW      = 4,
    parameter int GAP_CYC = 1
) (
    input  logic                 IQC,
    input  logic                 QRT_N,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*LW-1:0]   LEN,
    input  logic [NREQ-1:0]      MODE,
    input  logic [NREQ*W-1:0]    DATA,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      ACK,
    output logic [W-1:0]         OQI,
    output logic                 OSEL,
    output logic                 BUSY
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_next;
    logic [IW-1:0]   win;
    logic [LW-1:0]   cnt;
    logic [2:0]      gap_cnt;
    logic [NREQ-1:0] gnt_q;
    logic [W-1:0]    oqi_q;
    logic            osel_q;
    logic            any_req;
    logic            beat;
    logic            burst_end;

    // Winner is the first requester found scanning ptr, ptr+1, ... with wrap
    always_comb begin
        int   c;
        logic found;
        c     = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!found && REQ[c]) begin
                win   = IW'(c);
                found = 1'b1;
            end
        end
    end

    assign any_req   = |REQ;
    // A beat moves only while the owner keeps its request up
    assign beat      = (state == S_XFER) && (|(REQ & gnt_q));
    // Burst ends on the last counted beat or when the owner drops its request
    assign burst_end = (state == S_XFER) && (!beat || (cnt == '0));
    assign idx_next  = (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;

    // State register
    always_ff @(posedge IQC or negedge QRT_N) begin
        if (!QRT_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode for IDLE -> XFER -> GAP -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req)         state_nxt = S_XFER;
            S_XFER:  if (burst_end)       state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == '0)   state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // Grant, beat counter, pointer, gap timer and cell-bank drive registers
    always_ff @(posedge IQC or negedge QRT_N) begin
        if (!QRT_N) begin
            ptr     <= '0;
            idx     <= '0;
            cnt     <= '0;
            gap_cnt <= '0;
            gnt_q   <= '0;
            oqi_q   <= '0;
            osel_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        idx        <= win;
                        cnt        <= LEN[int'(win)*LW +: LW];
                        osel_q     <= MODE[win];
                        gnt_q      <= '0;
                        gnt_q[win] <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (beat) begin
                        oqi_q <= DATA[int'(idx)*W +: W];
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    if (burst_end) begin
                        gnt_q   <= '0;
                        ptr     <= idx_next;
                        gap_cnt <= 3'(GAP_CYC - 1);
                    end
                end
                S_GAP: begin
                    // Last beat stays visible for one cycle, then the bank input is flushed
                    oqi_q <= '0;
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    gnt_q <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        ACK  = (state == S_XFER) ? (REQ & gnt_q) : '0;
        BUSY = (state != S_IDLE);
    end

    assign GNT  = gnt_q;
    assign OQI  = oqi_q;
    assign OSEL = osel_q;

endmodule

// File: tb/tb_io_out_arbiter.sv
// tb/tb_io_out_arbiter.sv - scoreboard bench for io_out_arbiter
module tb_io_out_arbiter;

    logic        IQC   = 1'b0;
    logic        QRT_N = 1'b0;
    logic [3:0]  req   = '0;
    logic [15:0] len   = '0;
    logic [3:0]  mode  = '0;
    logic [31:0] data  = '0;

    logic [3:0]  gnt, ack, gnt3, ack3;
    logic [7:0]  oqi, oqi3;
    logic        osel, busy, osel3, busy3;

    io_out_arbiter #(.NREQ(4), .W(8), .LW(4), .GAP_CYC(1)) dut (
        .IQC(IQC), .QRT_N(QRT_N), .REQ(req), .LEN(len), .MODE(mode), .DATA(data),
        .GNT(gnt), .ACK(ack), .OQI(oqi), .OSEL(osel), .BUSY(busy)
    );

    io_out_arbiter #(.NREQ(4), .W(8), .LW(4), .GAP_CYC(3)) dut3 (
        .IQC(IQC), .QRT_N(QRT_N), .REQ(req), .LEN(len), .MODE(mode), .DATA(data),
        .GNT(gnt3), .ACK(ack3), .OQI(oqi3), .OSEL(osel3), .BUSY(busy3)
    );

    always #5 IQC = ~IQC;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    bit         pend = 1'b0;
    logic [3:0] prev_gnt = '0;
    logic [3:0] s_gnt, s_ack, s3_gnt;
    logic       s_busy;
    logic [3:0] h_gnt[$], h_ack[$], h3_gnt[$], h3_ack[$];
    logic [7:0] h_oqi[$], h3_oqi[$];
    logic       h_osel[$], h_busy[$], h3_osel[$];
    int         gq[$];

    task automatic clear_hist();
        h_gnt.delete(); h_ack.delete(); h_oqi.delete(); h_osel.delete(); h_busy.delete();
        h3_gnt.delete(); h3_ack.delete(); h3_oqi.delete(); h3_osel.delete();
        gq.delete();
    endtask

    // One clock cycle: sample outputs, run scoreboard, advance to next negedge
    task automatic step();
        logic [7:0] e;
        #1;
        s_gnt = gnt; s_ack = ack; s_busy = busy; s3_gnt = gnt3;
        h_gnt.push_back(gnt); h_ack.push_back(ack); h_oqi.push_back(oqi);
        h_osel.push_back(osel); h_busy.push_back(busy);
        h3_gnt.push_back(gnt3); h3_ack.push_back(ack3); h3_oqi.push_back(oqi3);
        h3_osel.push_back(osel3);
        n_cmp++;
        if (!$onehot0(gnt) || ((ack & ~gnt) != 0) || (!busy && gnt != 0)) begin
            n_bad++;
            $display("FAIL invariant: gnt=%b ack=%b busy=%b, required gnt onehot0, ack within gnt, idle without gnt", gnt, ack, busy);
        end
        if (pend) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (oqi !== e) begin
                n_bad++;
                $display("FAIL oqi_beat: got %h required %h", oqi, e);
            end
        end
        pend = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                exp_q.push_back(data[i*8 +: 8]);
                pend = 1'b1;
            end
        end
        if (gnt != 0 && prev_gnt == 0) begin
            for (int i = 0; i < 4; i++) if (gnt[i]) gq.push_back(i);
        end
        prev_gnt = gnt;
        @(posedge IQC);
        @(negedge IQC);
    endtask

    task automatic do_reset();
        pend = 1'b0;
        exp_q.delete();
        QRT_N = 1'b0;
        req = '0;
        step();
        step();
        QRT_N = 1'b1;
        clear_hist();
    endtask

    task automatic test_reset();
        int nack;
        step();
        step();
        #1;
        n_cmp++;
        if ({gnt, ack, oqi, osel, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got gnt=%b ack=%b oqi=%h osel=%b busy=%b required all 0", gnt, ack, oqi, osel, busy);
        end
        @(negedge IQC);
        QRT_N = 1'b1;
        req = 4'b0001; len = 16'h0005; mode = '0;
        nack = 0;
        for (int i = 0; i < 10; i++) begin
            data[7:0] = 8'(8'h50 + nack);
            step();
            if (s_ack[0]) nack++;
            if (nack == 2) break;
        end
        n_cmp++;
        if (nack != 2) begin
            n_bad++;
            $display("FAIL reset_preburst_acks: got %0d required 2", nack);
        end
        pend = 1'b0;
        exp_q.delete();
        QRT_N = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, ack, oqi, osel, busy} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got gnt=%b ack=%b oqi=%h osel=%b busy=%b required all 0", gnt, ack, oqi, osel, busy);
        end
        @(negedge IQC);
        step();
        step();
        QRT_N = 1'b1;
        clear_hist();
        nack = 0;
        for (int i = 0; i < 20; i++) begin
            data[7:0] = 8'(8'h60 + nack);
            if (nack == 6) req = '0;
            step();
            if (s_ack[0]) nack++;
        end
        n_cmp++;
        if (nack != 6) begin
            n_bad++;
            $display("FAIL reset_restart_beats: got %0d required 6", nack);
        end
        n_cmp++;
        if (gq.size() != 1 || gq[0] != 0) begin
            n_bad++;
            $display("FAIL reset_restart_owner: got %0d grants first=%0d required 1 grant to 0", gq.size(), (gq.size() > 0) ? gq[0] : -1);
        end
    endtask

    task automatic test_round_robin();
        int ai[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111; len = '0; mode = '0;
        data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 40; i++) begin
            if (gq.size() >= 5) break;
            step();
        end
        req = '0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (gq.size() != 5) begin
            n_bad++;
            $display("FAIL rr_grant_count: got %0d required 5", gq.size());
        end
        for (int k = 0; k < 5 && k < gq.size(); k++) begin
            n_cmp++;
            if (gq[k] != exp_order[k]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got %0d required %0d", k, gq[k], exp_order[k]);
            end
        end
        for (int i = 0; i < h_ack.size(); i++) if (h_ack[i] != 0) ai.push_back(i);
        n_cmp++;
        if (ai.size() != 5) begin
            n_bad++;
            $display("FAIL rr_ack_count: got %0d required 5", ai.size());
        end
        for (int k = 0; k + 1 < ai.size(); k++) begin
            n_cmp++;
            if (ai[k+1] - ai[k] != 3) begin
                n_bad++;
                $display("FAIL rr_ack_spacing[%0d]: got %0d required 3", k, ai[k+1] - ai[k]);
            end
        end
    endtask

    task automatic test_single();
        int nack, fa, la;
        clear_hist();
        len = 16'h0300; mode = 4'b0100; data = '0;
        nack = 0;
        for (int i = 0; i < 14; i++) begin
            data[23:16] = (nack < 4) ? 8'(8'h11 * (nack + 1)) : 8'h00;
            req = (nack == 4) ? 4'b0000 : 4'b0100;
            step();
            if (s_ack[2]) nack++;
        end
        fa = -1; la = -1;
        for (int i = 0; i < h_ack.size(); i++) begin
            if (h_ack[i] != 0) begin
                if (fa < 0) fa = i;
                la = i;
            end
        end
        n_cmp++;
        if (nack != 4 || la - fa != 3) begin
            n_bad++;
            $display("FAIL single_beats: got %0d acks over span %0d required 4 consecutive", nack, la - fa + 1);
        end
        n_cmp++;
        if (fa != 1) begin
            n_bad++;
            $display("FAIL single_latency: got first ack at cycle %0d required 1", fa);
        end
        if (fa >= 0 && la + 2 < h_ack.size()) begin
            n_cmp++;
            if (h_gnt[fa] !== 4'b0100 || h_osel[fa] !== 1'b1) begin
                n_bad++;
                $display("FAIL single_grant: got gnt=%b osel=%b required 0100 and 1", h_gnt[fa], h_osel[fa]);
            end
            n_cmp++;
            if (h_busy[la+1] !== 1'b1 || h_gnt[la+1] !== 4'b0000 || h_oqi[la+1] !== 8'h44 || h_osel[la+1] !== 1'b1) begin
                n_bad++;
                $display("FAIL single_gap: got busy=%b gnt=%b oqi=%h osel=%b required 1 0000 44 1", h_busy[la+1], h_gnt[la+1], h_oqi[la+1], h_osel[la+1]);
            end
            n_cmp++;
            if (h_busy[la+2] !== 1'b0 || h_oqi[la+2] !== 8'h00) begin
                n_bad++;
                $display("FAIL single_idle: got busy=%b oqi=%h required 0 00", h_busy[la+2], h_oqi[la+2]);
            end
        end
    endtask

    task automatic test_abort();
        int  n1, n2;
        bit  osel_ok;
        do_reset();
        len = 16'h0070; data = '0; data[23:16] = 8'hC2;
        n1 = 0; n2 = 0; osel_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            data[15:8] = 8'(8'h70 + n1);
            req[1]  = (n1 < 3);
            req[2]  = (gq.size() > 0) && (n2 == 0);
            mode[1] = (gq.size() == 0);
            step();
            if (s_ack[1]) begin
                n1++;
                if (h_osel[h_osel.size()-1] !== 1'b1) osel_ok = 1'b0;
            end
            if (s_ack[2]) n2++;
        end
        n_cmp++;
        if (n1 != 3) begin
            n_bad++;
            $display("FAIL abort_acks: got %0d required 3", n1);
        end
        n_cmp++;
        if (gq.size() != 2 || gq[0] != 1 || gq[1] != 2) begin
            n_bad++;
            $display("FAIL abort_next_owner: got %0d grants, second=%0d required owners 1 then 2", gq.size(), (gq.size() > 1) ? gq[1] : -1);
        end
        n_cmp++;
        if (!osel_ok || n2 != 1) begin
            n_bad++;
            $display("FAIL abort_mode_latched: got osel_held=%0b req2_acks=%0d required 1 and 1", osel_ok, n2);
        end
    endtask

    task automatic test_gap3();
        int a0, g1, zc;
        do_reset();
        req = 4'b0011; len = '0; mode = 4'b0010;
        data = {8'h00, 8'h00, 8'hB1, 8'hB0};
        for (int i = 0; i < 30; i++) begin
            step();
            if (s3_gnt == 4'b0010) break;
        end
        req = '0;
        for (int i = 0; i < 6; i++) step();
        a0 = -1; g1 = -1;
        for (int i = 0; i < h3_gnt.size(); i++) begin
            if (a0 < 0 && h3_ack[i][0]) a0 = i;
            if (g1 < 0 && h3_gnt[i] == 4'b0010) g1 = i;
        end
        n_cmp++;
        if (a0 < 0 || g1 < 0 || g1 - a0 - 1 != 4) begin
            n_bad++;
            $display("FAIL gap3_spacing: got %0d idle-grant cycles required 4", g1 - a0 - 1);
        end
        if (a0 >= 0 && g1 > a0) begin
            zc = 0;
            for (int i = a0 + 1; i < g1; i++) if (h3_gnt[i] == 0 && h3_oqi[i] == 0) zc++;
            n_cmp++;
            if (zc != 3) begin
                n_bad++;
                $display("FAIL gap3_quiet: got %0d cycles with gnt=0 oqi=0 required 3", zc);
            end
            n_cmp++;
            if (h3_oqi[a0+1] !== 8'hB0) begin
                n_bad++;
                $display("FAIL gap3_last_beat: got %h required b0", h3_oqi[a0+1]);
            end
            n_cmp++;
            if (h3_osel[g1-1] !== 1'b0 || h3_osel[g1] !== 1'b1) begin
                n_bad++;
                $display("FAIL gap3_osel_switch: got %b->%b required 0->1", h3_osel[g1-1], h3_osel[g1]);
            end
        end
    endtask

    task automatic test_max_len();
        int nack, fa, la;
        do_reset();
        req = 4'b0001; len = 16'h000F; mode = '0;
        nack = 0;
        for (int i = 0; i < 40; i++) begin
            data[7:0] = 8'(8'h30 + nack);
            if (nack == 16) req = '0;
            step();
            if (s_ack[0]) nack++;
        end
        fa = -1; la = -1;
        for (int i = 0; i < h_ack.size(); i++) begin
            if (h_ack[i] != 0) begin
                if (fa < 0) fa = i;
                la = i;
            end
        end
        n_cmp++;
        if (nack != 16 || la - fa != 15) begin
            n_bad++;
            $display("FAIL maxlen_beats: got %0d acks over span %0d required 16 consecutive", nack, la - fa + 1);
        end
        n_cmp++;
        if (gq.size() != 1 || s_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL maxlen_single_burst: got %0d grants busy=%b required 1 grant busy=0", gq.size(), s_busy);
        end
    endtask

    initial begin
        @(negedge IQC);
        test_reset();
        test_round_robin();
        test_single();
        test_abort();
        test_gap3();
        test_max_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
